// File: rtl/logic_sweep_engine_if.sv
// rtl/logic_sweep_engine_if.sv - config, control and row-stream bundle for logic_sweep_engine
// The host drives configuration/start and consumes rows; the engine produces rows and status.
interface logic_sweep_engine_if #(
  parameter int NUM_IN   = 4,
  parameter int NUM_FN   = 10,
  parameter int FN_SEL_W = 4
);
  logic                   cfg_we;
  logic [FN_SEL_W-1:0]    cfg_fn;
  logic [(1<<NUM_IN)-1:0] cfg_tt;
  logic                   start;
  logic                   mode;
  logic [NUM_IN-1:0]      eval_idx;
  logic                   busy;
  logic                   done;
  logic                   row_valid;
  logic                   row_ready;
  logic [NUM_IN-1:0]      row_idx;
  logic [NUM_FN-1:0]      row_out;
  logic [NUM_FN-1:0]      sig;

  modport master (
    output cfg_we, cfg_fn, cfg_tt, start, mode, eval_idx, row_ready,
    input  busy, done, row_valid, row_idx, row_out, sig
  );

  modport slave (
    input  cfg_we, cfg_fn, cfg_tt, start, mode, eval_idx, row_ready,
    output busy, done, row_valid, row_idx, row_out, sig
  );
endinterface

// File: rtl/logic_sweep_engine.sv
// rtl/logic_sweep_engine.sv - loadable LUT bank swept over all input rows, streamed out with an XOR signature
// Rows leave through a valid/ready port; the LUT bank is only writable while idle.
module logic_sweep_engine #(
  parameter int NUM_IN   = 4,
  parameter int NUM_FN   = 10,
  parameter int FN_SEL_W = 4
) (
  input logic                   clk_i,
  input logic                   rst_i,
  logic_sweep_engine_if.slave   bus
);
  localparam int ROWS = 1 << NUM_IN;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ROWS-1:0]   lut_q [NUM_FN];
  logic [ROWS-1:0]   lut_d [NUM_FN];
  logic [NUM_IN-1:0] idx_q, idx_d;
  logic [NUM_FN-1:0] out_q, out_d;
  logic [NUM_FN-1:0] sig_q, sig_d;
  logic              valid_q, valid_d;
  logic              single_q, single_d;
  logic              load_row;
  logic [NUM_FN-1:0] row_lookup;
  logic              cfg_hit;
  logic              xfer;
  logic              last_row;

  assign cfg_hit  = (state_q == ST_IDLE) && bus.cfg_we && (int'(bus.cfg_fn) < NUM_FN);
  assign xfer     = valid_q && bus.row_ready;
  assign last_row = single_q || (idx_q == NUM_IN'(ROWS - 1));

  // A write coincident with start must be visible to the first row, so rows read lut_d.
  always_comb begin
    for (int k = 0; k < NUM_FN; k++) begin
      lut_d[k] = lut_q[k];
      if (cfg_hit && (int'(bus.cfg_fn) == k)) begin
        lut_d[k] = bus.cfg_tt;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sig_d    = sig_q;
    valid_d  = valid_q;
    single_d = single_q;
    load_row = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d  = ST_SWEEP;
          valid_d  = 1'b1;
          sig_d    = '0;
          single_d = bus.mode;
          idx_d    = bus.mode ? bus.eval_idx : '0;
          load_row = 1'b1;
        end
      end
      ST_SWEEP: begin
        if (xfer) begin
          sig_d = sig_q ^ out_q;
          if (last_row) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
          end else begin
            idx_d    = idx_q + NUM_IN'(1);
            load_row = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    for (int k = 0; k < NUM_FN; k++) begin
      row_lookup[k] = lut_d[k][idx_d];
    end
  end

  assign out_d = load_row ? row_lookup : out_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      out_q    <= '0;
      sig_q    <= '0;
      valid_q  <= 1'b0;
      single_q <= 1'b0;
      for (int k = 0; k < NUM_FN; k++) begin
        lut_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      out_q    <= out_d;
      sig_q    <= sig_d;
      valid_q  <= valid_d;
      single_q <= single_d;
      for (int k = 0; k < NUM_FN; k++) begin
        lut_q[k] <= lut_d[k];
      end
    end
  end

  assign bus.busy      = (state_q == ST_SWEEP);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.row_valid = valid_q;
  assign bus.row_idx   = idx_q;
  assign bus.row_out   = out_q;
  assign bus.sig       = sig_q;
endmodule

// File: tb/tb_logic_sweep_engine.sv
// tb/tb_logic_sweep_engine.sv - directed table-driven bench for logic_sweep_engine
module tb_logic_sweep_engine;
  logic clk;
  logic rst;

  logic_sweep_engine_if #(.NUM_IN(4), .NUM_FN(10), .FN_SEL_W(4)) bus ();

  logic_sweep_engine #(.NUM_IN(4), .NUM_FN(10), .FN_SEL_W(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ready;
    logic       valid;
    logic [3:0] idx;
    logic [9:0] out;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tab [17];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [3:0] fn, input logic [15:0] tt);
    bus.cfg_we = 1'b1;
    bus.cfg_fn = fn;
    bus.cfg_tt = tt;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic do_start(input logic m, input logic [3:0] e);
    bus.start    = 1'b1;
    bus.mode     = m;
    bus.eval_idx = e;
    tick();
    bus.start    = 1'b0;
    bus.mode     = 1'b0;
    bus.eval_idx = '0;
    bus.cfg_we   = 1'b0;
  endtask

  // Applies the full-sweep table; inj_at pulses a foreign cfg write and start at that row.
  task automatic run_table(input string tag, input int inj_at, input logic [9:0] or_mask, input bit zero_out);
    logic [9:0] exp_out;
    for (int i = 0; i < 17; i++) begin
      bus.row_ready = tab[i].ready;
      exp_out = zero_out ? 10'h000 : (tab[i].out | or_mask);
      chk($sformatf("%s_r%0d_valid", tag, i), 32'(bus.row_valid), 32'(tab[i].valid));
      chk($sformatf("%s_r%0d_busy", tag, i), 32'(bus.busy), 32'(tab[i].busy));
      chk($sformatf("%s_r%0d_done", tag, i), 32'(bus.done), 32'(tab[i].done));
      if (tab[i].valid) begin
        chk($sformatf("%s_r%0d_idx", tag, i), 32'(bus.row_idx), 32'(tab[i].idx));
        chk($sformatf("%s_r%0d_out", tag, i), 32'(bus.row_out), 32'(exp_out));
      end
      if (i == inj_at) begin
        bus.cfg_we = 1'b1; bus.cfg_fn = 4'd4; bus.cfg_tt = 16'h0000;
        bus.start  = 1'b1; bus.mode   = 1'b1; bus.eval_idx = 4'd0;
      end
      tick();
      bus.cfg_we = 1'b0; bus.start = 1'b0; bus.mode = 1'b0;
    end
  endtask

  task automatic single(input string tag, input logic [3:0] e, input logic [9:0] exp_out);
    do_start(1'b1, e);
    bus.row_ready = 1'b1;
    chk({tag, "_valid"}, 32'(bus.row_valid), 32'd1);
    chk({tag, "_busy"},  32'(bus.busy), 32'd1);
    chk({tag, "_idx"},   32'(bus.row_idx), 32'(e));
    chk({tag, "_out"},   32'(bus.row_out), 32'(exp_out));
    tick();
    chk({tag, "_done"},  32'(bus.done), 32'd1);
    chk({tag, "_busy0"}, 32'(bus.busy), 32'd0);
    chk({tag, "_valid0"}, 32'(bus.row_valid), 32'd0);
    chk({tag, "_sig"},   32'(bus.sig), 32'(exp_out));
    tick();
    chk({tag, "_done0"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int         cyc;
    int         held;
    int         seen5;
    int         done_cyc;
    bit         done_seen;
    logic [9:0] exp16 [16];

    // LUT4 = 0x8888 -> bit4 at idx 3,7,11,15; LUT5 = 0x111F -> bit5 at 0-4,8,12
    exp16 = '{10'h020, 10'h020, 10'h020, 10'h030, 10'h020, 10'h000, 10'h000, 10'h010,
              10'h020, 10'h000, 10'h000, 10'h010, 10'h020, 10'h000, 10'h000, 10'h010};
    for (int i = 0; i < 16; i++) begin
      tab[i] = '{ready: 1'b1, valid: 1'b1, idx: 4'(i), out: exp16[i], busy: 1'b1, done: 1'b0};
    end
    tab[16] = '{ready: 1'b1, valid: 1'b0, idx: 4'd0, out: 10'h000, busy: 1'b0, done: 1'b1};

    rst = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_fn = '0; bus.cfg_tt = '0;
    bus.start = 1'b0; bus.mode = 1'b0; bus.eval_idx = '0; bus.row_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(bus.row_valid), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_done",  32'(bus.done), 32'd0);
    chk("rst_idx",   32'(bus.row_idx), 32'd0);
    chk("rst_out",   32'(bus.row_out), 32'd0);
    chk("rst_sig",   32'(bus.sig), 32'd0);
    rst = 1'b0;
    tick();

    // Test 1: full sweep, ready held high
    cfg(4'd4, 16'h8888);
    cfg(4'd5, 16'h111F);
    do_start(1'b0, 4'd0);
    run_table("t1", -1, 10'h000, 1'b0);
    chk("t1_sig", 32'(bus.sig), 32'h020);
    chk("t1_idle_done", 32'(bus.done), 32'd0);

    // Test 2: stall 3 cycles on idx 5
    do_start(1'b0, 4'd0);
    cyc = 0; held = 0; seen5 = 0; done_seen = 0; done_cyc = -1;
    while (cyc < 40 && !done_seen) begin
      if (bus.done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end else begin
        if (bus.row_idx == 4'd5 && bus.row_valid) begin
          seen5++;
          chk($sformatf("t2_hold_out%0d", seen5), 32'(bus.row_out), 32'h000);
        end
        if (bus.row_idx == 4'd5 && held < 3) begin
          bus.row_ready = 1'b0;
          held++;
        end else begin
          bus.row_ready = 1'b1;
        end
        tick();
        cyc++;
      end
    end
    bus.row_ready = 1'b1;
    chk("t2_done_seen", 32'(done_seen), 32'd1);
    chk("t2_done_cyc", 32'(done_cyc), 32'd19);
    chk("t2_idx5_cycles", 32'(seen5), 32'd4);
    chk("t2_sig", 32'(bus.sig), 32'h020);
    tick();

    // Test 3: single-row evaluation
    single("t3", 4'd11, 10'h010);

    // Test 4: cfg write and start during a sweep are ignored
    do_start(1'b0, 4'd0);
    run_table("t4", 6, 10'h000, 1'b0);
    chk("t4_sig", 32'(bus.sig), 32'h020);
    single("t4_lut4", 4'd3, 10'h030);

    // Test 5: out-of-range fn, then write coincident with start
    cfg(4'd12, 16'hFFFF);
    single("t5_fn12", 4'd0, 10'h020);
    bus.cfg_we = 1'b1; bus.cfg_fn = 4'd0; bus.cfg_tt = 16'hFFFF;
    do_start(1'b0, 4'd0);
    run_table("t5", -1, 10'h001, 1'b0);
    chk("t5_sig", 32'(bus.sig), 32'h020);

    // Test 6: asynchronous reset mid-sweep
    do_start(1'b0, 4'd0);
    bus.row_ready = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("t6_pre_idx", 32'(bus.row_idx), 32'd7);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(bus.row_valid), 32'd0);
    chk("t6_rst_busy",  32'(bus.busy), 32'd0);
    chk("t6_rst_done",  32'(bus.done), 32'd0);
    chk("t6_rst_idx",   32'(bus.row_idx), 32'd0);
    chk("t6_rst_out",   32'(bus.row_out), 32'd0);
    chk("t6_rst_sig",   32'(bus.sig), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t6_nodone%0d", i), 32'(bus.done), 32'd0);
    end
    do_start(1'b0, 4'd0);
    run_table("t6", -1, 10'h000, 1'b1);
    chk("t6_sig", 32'(bus.sig), 32'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
